// File: rtl/ccr_pkg.sv
// Shared constants for the condition-code register stage: flag bit positions,
// CCR width and conditional-jump encodings.
package ccr_pkg;

   localparam int unsigned FLAG_W = 3;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_C = 2;

   typedef enum logic [1:0] {
      JMP_NONE = 2'b00,
      JMP_Z    = 2'b01,
      JMP_N    = 2'b10,
      JMP_C    = 2'b11
   } jmp_e;

endpackage

// File: rtl/ccr_shadow_stack.sv
// LIFO holding saved CCR values across nested interrupts, with sticky
// overflow/underflow flags. Pop takes precedence over push in the same cycle.
module ccr_shadow_stack #(
   parameter int unsigned W     = 3,
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic                           push,
   input  logic                           pop,
   input  logic [W-1:0]                   din,
   output logic [W-1:0]                   top,
   output logic [$clog2(DEPTH+1)-1:0]     depth,
   output logic                           empty,
   output logic                           ovf_err,
   output logic                           unf_err
);

   localparam int unsigned DW = $clog2(DEPTH + 1);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic          full;
   logic [IW-1:0] wr_idx;
   logic [IW-1:0] rd_idx;

   assign full   = (depth == FULL_CNT);
   assign empty  = (depth == '0);
   // Indices only ever address valid entries, so narrowing to the array index width is exact.
   assign wr_idx = IW'(depth);
   assign rd_idx = IW'(depth - 1'b1);
   assign top    = empty ? '0 : mem[rd_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth   <= '0;
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (en) begin
         if (pop) begin
            if (empty) unf_err <= 1'b1;
            else       depth   <= depth - 1'b1;
         end else if (push) begin
            if (full) begin
               ovf_err <= 1'b1;
            end else begin
               mem[wr_idx] <= din;
               depth       <= depth + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ccr_unit.sv
// Architectural condition-code register: masked ALU flag capture, conditional
// jump resolution with tested-flag clear, and interrupt save/restore.
module ccr_unit #(
   parameter int unsigned FLAG_W      = ccr_pkg::FLAG_W,
   parameter int unsigned STACK_DEPTH = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [FLAG_W-1:0]                    alu_flag,
   input  logic [FLAG_W-1:0]                    alu_flag_we,
   input  logic [1:0]                           jmp_type,
   input  logic                                 stall,
   input  logic                                 flush,
   input  logic                                 int_save,
   input  logic                                 rti_restore,
   output logic [FLAG_W-1:0]                    ccr,
   output logic                                 branch_taken,
   output logic [$clog2(STACK_DEPTH+1)-1:0]     stack_depth,
   output logic                                 ovf_err,
   output logic                                 unf_err
);

   import ccr_pkg::*;

   logic [FLAG_W-1:0] ccr_upd;
   logic [FLAG_W-1:0] ccr_next;
   logic [FLAG_W-1:0] stk_top;
   logic              stk_empty;
   logic              restore_hit;

   always_comb begin
      branch_taken = 1'b0;
      if (!stall && !flush) begin
         case (jmp_type)
            JMP_Z:   branch_taken = ccr[FLAG_Z];
            JMP_N:   branch_taken = ccr[FLAG_N];
            JMP_C:   branch_taken = ccr[FLAG_C];
            default: branch_taken = 1'b0;
         endcase
      end
   end

   // Jump clear is applied after the ALU merge so it wins over a same-bit write.
   always_comb begin
      ccr_upd = ccr;
      if (!flush) ccr_upd = (alu_flag & alu_flag_we) | (ccr & ~alu_flag_we);
      if (branch_taken) begin
         case (jmp_type)
            JMP_Z:   ccr_upd[FLAG_Z] = 1'b0;
            JMP_N:   ccr_upd[FLAG_N] = 1'b0;
            JMP_C:   ccr_upd[FLAG_C] = 1'b0;
            default: ;
         endcase
      end
      restore_hit = rti_restore && !stk_empty;
      ccr_next    = restore_hit ? stk_top : ccr_upd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         ccr <= '0;
      else if (!stall) ccr <= ccr_next;
   end

   ccr_shadow_stack #(
      .W     (FLAG_W),
      .DEPTH (STACK_DEPTH)
   ) u_shadow_stack (
      .clk     (clk),
      .rst     (rst),
      .en      (!stall),
      .push    (int_save && !rti_restore),
      .pop     (rti_restore),
      .din     (ccr_next),
      .top     (stk_top),
      .depth   (stack_depth),
      .empty   (stk_empty),
      .ovf_err (ovf_err),
      .unf_err (unf_err)
   );

endmodule

// File: tb/tb_ccr_unit.sv
// Self-checking bench for ccr_unit: per-cycle expected state is queued when
// stimulus is applied and checked after the following clock edge.
module tb_ccr_unit;

   localparam logic [1:0] J_NONE = 2'b00;
   localparam logic [1:0] J_Z    = 2'b01;
   localparam logic [1:0] J_N    = 2'b10;
   localparam logic [1:0] J_C    = 2'b11;

   logic       clk;
   logic       rst;
   logic [2:0] alu_flag;
   logic [2:0] alu_flag_we;
   logic [1:0] jmp_type;
   logic       stall;
   logic       flush;
   logic       int_save;
   logic       rti_restore;
   logic [2:0] ccr;
   logic       branch_taken;
   logic [1:0] stack_depth;
   logic       ovf_err;
   logic       unf_err;

   typedef struct {
      string      name;
      logic [6:0] st;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   ccr_unit #(
      .FLAG_W      (3),
      .STACK_DEPTH (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .alu_flag     (alu_flag),
      .alu_flag_we  (alu_flag_we),
      .jmp_type     (jmp_type),
      .stall        (stall),
      .flush        (flush),
      .int_save     (int_save),
      .rti_restore  (rti_restore),
      .ccr          (ccr),
      .branch_taken (branch_taken),
      .stack_depth  (stack_depth),
      .ovf_err      (ovf_err),
      .unf_err      (unf_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scoreboard: one queued expectation is retired just after each rising edge.
   initial begin
      exp_t       e;
      logic [6:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {ccr, stack_depth, ovf_err, unf_err};
            checks++;
            if (got !== e.st) begin
               errors++;
               $display("FAIL %s: got ccr=%b depth=%0d ovf=%b unf=%b, expected ccr=%b depth=%0d ovf=%b unf=%b",
                        e.name, got[6:4], got[3:2], got[1], got[0],
                        e.st[6:4], e.st[3:2], e.st[1], e.st[0]);
            end
         end
      end
   end

   task automatic set_in(input logic [2:0] af, input logic [2:0] we, input logic [1:0] jt,
                         input logic st, input logic fl, input logic sv, input logic rr);
      alu_flag    = af;
      alu_flag_we = we;
      jmp_type    = jt;
      stall       = st;
      flush       = fl;
      int_save    = sv;
      rti_restore = rr;
   endtask

   task automatic expect_state(input string nm, input logic [2:0] c, input logic [1:0] d,
                               input logic o, input logic u);
      exp_t e;
      e.name = nm;
      e.st   = {c, d, o, u};
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({ccr, stack_depth, ovf_err, unf_err, branch_taken} !== 8'b0) begin
         errors++;
         $display("FAIL reset_state: ccr=%b depth=%0d ovf=%b unf=%b bt=%b, expected all zero",
                  ccr, stack_depth, ovf_err, unf_err, branch_taken);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_alu_async_reset();
      set_in(3'b101, 3'b111, J_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_state("alu_add_save", 3'b101, 2'd1, 1'b0, 1'b0);
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ccr, stack_depth, ovf_err, unf_err} !== 7'b0) begin
         errors++;
         $display("FAIL async_reset: ccr=%b depth=%0d ovf=%b unf=%b, expected ccr=000 depth=0",
                  ccr, stack_depth, ovf_err, unf_err);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_jz();
      apply_reset();
      set_in(3'b001, 3'b111, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("load_001", 3'b001, 2'd0, 1'b0, 1'b0);
      set_in(3'b111, 3'b111, J_Z, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (branch_taken !== 1'b0) begin
         errors++;
         $display("FAIL jz_stall_bt: branch_taken=%b expected 0", branch_taken);
      end
      expect_state("jz_stall_hold", 3'b001, 2'd0, 1'b0, 1'b0);
      set_in(3'b000, 3'b000, J_Z, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (branch_taken !== 1'b1) begin
         errors++;
         $display("FAIL jz_taken_bt: branch_taken=%b expected 1", branch_taken);
      end
      expect_state("jz_taken_clear", 3'b000, 2'd0, 1'b0, 1'b0);
      set_in(3'b000, 3'b000, J_Z, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (branch_taken !== 1'b0) begin
         errors++;
         $display("FAIL jz_not_taken_bt: branch_taken=%b expected 0", branch_taken);
      end
      expect_state("jz_not_taken", 3'b000, 2'd0, 1'b0, 1'b0);
      set_in(3'b001, 3'b001, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("reload_001", 3'b001, 2'd0, 1'b0, 1'b0);
      set_in(3'b001, 3'b001, J_Z, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("clear_beats_write", 3'b000, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic test_setc_clrc();
      apply_reset();
      set_in(3'b010, 3'b111, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("load_010", 3'b010, 2'd0, 1'b0, 1'b0);
      set_in(3'b100, 3'b100, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("setc", 3'b110, 2'd0, 1'b0, 1'b0);
      set_in(3'b100, 3'b111, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("load_100", 3'b100, 2'd0, 1'b0, 1'b0);
      set_in(3'b000, 3'b100, J_C, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (branch_taken !== 1'b1) begin
         errors++;
         $display("FAIL jc_taken_bt: branch_taken=%b expected 1", branch_taken);
      end
      expect_state("clrc_jc", 3'b000, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic test_int_save_inflight();
      apply_reset();
      set_in(3'b011, 3'b111, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("load_011", 3'b011, 2'd0, 1'b0, 1'b0);
      set_in(3'b100, 3'b100, J_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_state("save_inflight", 3'b111, 2'd1, 1'b0, 1'b0);
      set_in(3'b000, 3'b111, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("load_000", 3'b000, 2'd1, 1'b0, 1'b0);
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_state("rti_restore_111", 3'b111, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic test_overflow_underflow();
      apply_reset();
      set_in(3'b001, 3'b111, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("ovf_load_001", 3'b001, 2'd0, 1'b0, 1'b0);
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_state("push1", 3'b001, 2'd1, 1'b0, 1'b0);
      set_in(3'b010, 3'b111, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("ovf_load_010", 3'b010, 2'd1, 1'b0, 1'b0);
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_state("push2", 3'b010, 2'd2, 1'b0, 1'b0);
      set_in(3'b100, 3'b111, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("ovf_load_100", 3'b100, 2'd2, 1'b0, 1'b0);
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b1, 1'b0);
      expect_state("push3_overflow", 3'b100, 2'd2, 1'b1, 1'b0);
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_state("pop1_second_push", 3'b010, 2'd1, 1'b1, 1'b0);
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_state("pop2_first_push", 3'b001, 2'd0, 1'b1, 1'b0);
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_state("pop3_underflow", 3'b001, 2'd0, 1'b1, 1'b1);
      set_in(3'b110, 3'b111, J_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_state("pop_empty_alu_update", 3'b110, 2'd0, 1'b1, 1'b1);
   endtask

   task automatic test_flush_and_save_restore();
      apply_reset();
      set_in(3'b010, 3'b111, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("flush_load_010", 3'b010, 2'd0, 1'b0, 1'b0);
      set_in(3'b111, 3'b111, J_N, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (branch_taken !== 1'b0) begin
         errors++;
         $display("FAIL flush_jn_bt: branch_taken=%b expected 0", branch_taken);
      end
      expect_state("flush_hold", 3'b010, 2'd0, 1'b0, 1'b0);
      set_in(3'b111, 3'b111, J_NONE, 1'b0, 1'b1, 1'b1, 1'b0);
      expect_state("flush_save", 3'b010, 2'd1, 1'b0, 1'b0);
      set_in(3'b101, 3'b111, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_state("load_101", 3'b101, 2'd1, 1'b0, 1'b0);
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b1, 1'b1);
      expect_state("save_and_restore", 3'b010, 2'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_alu_async_reset();
      test_jz();
      test_setc_clrc();
      test_int_save_inflight();
      test_overflow_underflow();
      test_flush_and_save_restore();
      set_in(3'b000, 3'b000, J_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
